ex_muldiv: RTL and testbench

- RV32M multiply/divide unit for the execute stage.
- Consumes the operation fields latched by the ID/EX pipeline register and produces a write-back result, which the EX result mux selects.
- MUL-family ops complete in one cycle. DIV/REM-family ops run an iterative 32-step divider and hold the pipeline through stallreq_o. The ID/EX register keeps the instruction stable while stall[2] and stall[3] are both Stop.

---
 rtl/ex_muldiv_pkg.sv | 32 +++
 rtl/ex_muldiv_div_core.sv | 58 +++++
 rtl/ex_muldiv.sv | 130 +++++++++++++
 tb/tb_ex_muldiv.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_pkg.sv
// Shared constants and types for the RV32M execute-stage multiply/divide unit.
package ex_muldiv_pkg;

  localparam logic       RST_ENABLE   = 1'b1;
  localparam logic       STOP         = 1'b1;
  localparam logic [4:0] NOP_REG_ADDR = 5'd0;

  localparam logic [6:0] OP_REG      = 7'b0110011;
  localparam logic [6:0] FUN7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    F3_MUL    = 3'd0,
    F3_MULH   = 3'd1,
    F3_MULHSU = 3'd2,
    F3_MULHU  = 3'd3,
    F3_DIV    = 3'd4,
    F3_DIVU   = 3'd5,
    F3_REM    = 3'd6,
    F3_REMU   = 3'd7
  } md_fun3_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

  // Signed division overflow: most negative dividend divided by -1.
  localparam logic [31:0] SOVF_DIVIDEND = 32'h8000_0000;
  localparam logic [31:0] SOVF_DIVISOR  = 32'hFFFF_FFFF;

endpackage

// File: rtl/ex_muldiv_div_core.sv
// Unsigned restoring divider producing one quotient bit per cycle.
module ex_muldiv_div_core
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int DIV_STEPS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            done
);

  localparam int            CW   = $clog2(DIV_STEPS);
  localparam logic [CW-1:0] LAST = CW'(DIV_STEPS - 1);

  logic [XLEN-1:0] quo, rem, dvs;
  logic [CW-1:0]   count;
  logic            busy;
  logic [XLEN:0]   shifted, diff;

  // Partial remainder stays below the divisor, so bit XLEN of diff is the borrow.
  assign shifted = {rem, quo[XLEN-1]};
  assign diff    = shifted - {1'b0, dvs};

  // NOTE: every register here uses <= so all bits update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE || abort) begin
      quo   <= '0;
      rem   <= '0;
      dvs   <= '0;
      count <= '0;
      busy  <= 1'b0;
    end else if (start) begin
      quo   <= dividend;
      rem   <= '0;
      dvs   <= divisor;
      count <= '0;
      busy  <= 1'b1;
    end else if (busy) begin
      quo   <= {quo[XLEN-2:0], ~diff[XLEN]};
      rem   <= diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
      count <= count + 1'b1;
      if (count == LAST) busy <= 1'b0;
    end
  end

  // Asserted during the final step; results are valid after that edge.
  assign done      = busy && (count == LAST);
  assign quotient  = quo;
  assign remainder = rem;

endmodule

// File: rtl/ex_muldiv.sv
// RV32M multiply/divide unit: single-cycle multiplier, iterative divider with pipeline stall.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int DIV_STEPS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [5:0]      stall,
  input  logic            annul_i,
  input  logic [6:0]      aluop_i,
  input  logic [2:0]      alufun3_i,
  input  logic [6:0]      alufun7_i,
  input  logic [XLEN-1:0] reg1_i,
  input  logic [XLEN-1:0] reg2_i,
  input  logic [4:0]      wd_i,
  input  logic            wreg_i,
  output logic            md_valid_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [4:0]      wd_o,
  output logic            wreg_o,
  output logic            stallreq_o
);

  md_state_e         state;
  logic              is_mop, is_div, op_signed, a_neg, b_neg;
  logic              div_zero, div_ovf, special, core_start, core_done;
  logic              a_sx, b_sx;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   abs_a, abs_b, sp_res_d, quotient, remainder, mag, div_res;
  logic              neg_res, is_rem, special_q;
  logic [XLEN-1:0]   sp_res;
  logic              unused_stall;

  assign unused_stall = ^{stall[5:4], stall[2:0]};

  assign is_mop    = (aluop_i == OP_REG) && (alufun7_i == FUN7_MULDIV);
  assign is_div    = is_mop && alufun3_i[2];
  assign op_signed = !alufun3_i[0];
  assign a_neg     = op_signed && reg1_i[XLEN-1];
  assign b_neg     = op_signed && reg2_i[XLEN-1];
  assign abs_a     = a_neg ? -reg1_i : reg1_i;
  assign abs_b     = b_neg ? -reg2_i : reg2_i;

  assign div_zero = (reg2_i == '0);
  assign div_ovf  = op_signed && (reg1_i == SOVF_DIVIDEND) && (reg2_i == SOVF_DIVISOR);
  assign special  = div_zero || div_ovf;
  assign sp_res_d = div_zero ? (alufun3_i[1] ? reg1_i : '1)
                             : (alufun3_i[1] ? '0 : SOVF_DIVIDEND);

  assign core_start = (rst != RST_ENABLE) && !annul_i && (state == ST_IDLE) && is_div && !special;

  // Sign-extending to 2*XLEN makes one unsigned multiply serve all four variants.
  assign a_sx = ((alufun3_i == F3_MULH) || (alufun3_i == F3_MULHSU)) && reg1_i[XLEN-1];
  assign b_sx = (alufun3_i == F3_MULH) && reg2_i[XLEN-1];
  assign prod = {{XLEN{a_sx}}, reg1_i} * {{XLEN{b_sx}}, reg2_i};

  ex_muldiv_div_core #(.XLEN(XLEN), .DIV_STEPS(DIV_STEPS)) u_div_core (
    .clk       (clk),
    .rst       (rst),
    .start     (core_start),
    .abort     (annul_i),
    .dividend  (abs_a),
    .divisor   (abs_b),
    .quotient  (quotient),
    .remainder (remainder),
    .done      (core_done)
  );

  assign mag     = is_rem ? remainder : quotient;
  assign div_res = special_q ? sp_res : (neg_res ? -mag : mag);

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state     <= ST_IDLE;
      neg_res   <= 1'b0;
      is_rem    <= 1'b0;
      special_q <= 1'b0;
      sp_res    <= '0;
    end else if (annul_i) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (is_div) begin
          is_rem    <= alufun3_i[1];
          neg_res   <= alufun3_i[1] ? a_neg : (a_neg ^ b_neg);
          special_q <= special;
          sp_res    <= sp_res_d;
          state     <= special ? ST_DONE : ST_BUSY;
        end
        ST_BUSY: if (core_done) state <= ST_DONE;
        // Downstream stall keeps ID/EX frozen, so the result must be held.
        ST_DONE: if (stall[3] != STOP) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: outputs are decoded combinationally and every one gets a default first, so no latch
  // is inferred and MUL results and stall requests land in the instruction's own EX cycle.
  always_comb begin
    md_valid_o = 1'b0;
    wdata_o    = '0;
    wreg_o     = 1'b0;
    stallreq_o = 1'b0;
    wd_o       = (rst == RST_ENABLE) ? NOP_REG_ADDR : wd_i;
    if (rst != RST_ENABLE && !annul_i) begin
      case (state)
        ST_IDLE: if (is_mop) begin
          if (is_div) begin
            stallreq_o = 1'b1;
          end else begin
            md_valid_o = 1'b1;
            wreg_o     = wreg_i;
            wdata_o    = (alufun3_i == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
          end
        end
        ST_BUSY: stallreq_o = 1'b1;
        ST_DONE: begin
          md_valid_o = 1'b1;
          wreg_o     = wreg_i;
          wdata_o    = div_res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Randomized and directed bench for ex_muldiv against an arithmetic RV32M reference model.
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;

  logic        clk, rst, annul_i, wreg_i;
  logic [5:0]  stall;
  logic [6:0]  aluop_i, alufun7_i;
  logic [2:0]  alufun3_i;
  logic [31:0] reg1_i, reg2_i;
  logic [4:0]  wd_i;
  logic        md_valid_o, wreg_o, stallreq_o;
  logic [31:0] wdata_o;
  logic [4:0]  wd_o;

  int n_pass  = 0;
  int n_total = 0;

  ex_muldiv dut (
    .clk(clk), .rst(rst), .stall(stall), .annul_i(annul_i),
    .aluop_i(aluop_i), .alufun3_i(alufun3_i), .alufun7_i(alufun7_i),
    .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .md_valid_o(md_valid_o), .wdata_o(wdata_o), .wd_o(wd_o),
    .wreg_o(wreg_o), .stallreq_o(stallreq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Reference: RV32M arithmetic written directly from the ISA rules.
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] p;
    int sa, sb;
    logic ovf;
    sa  = $signed(a);
    sb  = $signed(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = longint'(sa) * longint'(sb);     return p[31:0];  end
      3'd1: begin p = longint'(sa) * longint'(sb);     return p[63:32]; end
      3'd2: begin p = longint'(sa) * longint'({32'b0, a} & 64'h0 | {32'b0, b}); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b};         return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Cycles the op occupies EX before its result shows (MUL 1, special divide 2, divide 34).
  function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
    if (!f3[2]) return 1;
    if (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 2;
    return 34;
  endfunction

  task automatic drive_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    aluop_i   = OP_REG;
    alufun7_i = FUN7_MULDIV;
    alufun3_i = f3;
    reg1_i    = a;
    reg2_i    = b;
    wd_i      = 5'($urandom_range(1, 31));
    wreg_i    = 1'($urandom_range(0, 1));
  endtask

  task automatic drive_nop();
    aluop_i   = OP_REG;
    alufun7_i = 7'b0000000;
    alufun3_i = 3'd0;
    reg1_i    = 32'h1234_5678;
    reg2_i    = 32'h0000_0003;
    wd_i      = 5'd7;
    wreg_i    = 1'b1;
  endtask

  // Called just after a posedge; returns just after a later posedge with a NOP driven.
  task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input int hold);
    int cycles, stalls;
    bit seen;
    logic [31:0] exp;
    exp = ref_result(f3, a, b);
    drive_op(f3, a, b);
    cycles = 0;
    stalls = 0;
    seen   = 0;
    while (!seen && cycles < 100) begin
      @(negedge clk);
      cycles++;
      if (stallreq_o) stalls++;
      if (md_valid_o) seen = 1;
    end
    check({tag, "_latency"}, cycles, ref_latency(f3, a, b));
    check({tag, "_stall_cycles"}, stalls, ref_latency(f3, a, b) - 1);
    check({tag, "_wdata"}, wdata_o, exp);
    check({tag, "_wreg"}, {31'b0, wreg_o}, {31'b0, wreg_i});
    check({tag, "_wd"}, {27'b0, wd_o}, {27'b0, wd_i});
    if (hold > 0) begin
      stall = 6'b011000;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        @(negedge clk);
        check({tag, "_hold_valid"}, {31'b0, md_valid_o}, 32'd1);
        check({tag, "_hold_wdata"}, wdata_o, exp);
        check({tag, "_hold_stallreq"}, {31'b0, stallreq_o}, 32'd0);
      end
      stall = 6'b000000;
    end
    @(posedge clk);
    #1;
    drive_nop();
  endtask

  task automatic check_quiet(input string tag, input logic [4:0] exp_wd);
    check({tag, "_valid"}, {31'b0, md_valid_o}, 32'd0);
    check({tag, "_stallreq"}, {31'b0, stallreq_o}, 32'd0);
    check({tag, "_wreg"}, {31'b0, wreg_o}, 32'd0);
    check({tag, "_wdata"}, wdata_o, 32'd0);
    check({tag, "_wd"}, {27'b0, wd_o}, {27'b0, exp_wd});
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a, b;
    rst     = 1'b1;
    stall   = 6'b0;
    annul_i = 1'b0;
    drive_op(3'd4, 32'd100, 32'd3);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check_quiet("reset", 5'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive_nop();

    @(negedge clk);
    check_quiet("not_mop_add", wd_i);
    @(posedge clk);
    #1;
    aluop_i   = 7'b0010011;
    alufun7_i = FUN7_MULDIV;
    alufun3_i = 3'd4;
    @(negedge clk);
    check_quiet("not_mop_opimm", wd_i);
    @(posedge clk);
    #1;
    drive_nop();

    do_op("mul_neg",    3'd0, 32'd7,          32'hFFFF_FFFD, 0);
    do_op("mulh_min",   3'd1, 32'h8000_0000,  32'h8000_0000, 0);
    do_op("mulhu_min",  3'd3, 32'h8000_0000,  32'h8000_0000, 0);
    do_op("mulhsu_neg", 3'd2, 32'hFFFF_FFFF,  32'd2,         0);
    do_op("div_neg",    3'd4, 32'hFFFF_FFF9,  32'd2,         0);
    do_op("rem_neg",    3'd6, 32'hFFFF_FFF9,  32'd2,         0);
    do_op("divu_zero",  3'd5, 32'd100,        32'd0,         0);
    do_op("remu_zero",  3'd7, 32'd100,        32'd0,         0);
    do_op("div_ovf",    3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 0);
    do_op("rem_ovf",    3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 0);

    do_op("divu_held",  3'd5, 32'd1000,       32'd7,         3);
    do_op("divu_b2b",   3'd5, 32'd1000,       32'd7,         0);

    // Reset in the middle of a divide, while the step counter reads 10.
    drive_op(3'd4, 32'hFFFF_FFF9, 32'd2);
    repeat (11) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_quiet("rst_mid_div", 5'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive_nop();
    @(negedge clk);
    check_quiet("after_rst", wd_i);
    @(posedge clk);
    #1;

    // Flush while the step counter reads 5.
    drive_op(3'd4, 32'd1000, 32'd3);
    repeat (6) @(posedge clk);
    #1;
    annul_i = 1'b1;
    @(negedge clk);
    check("annul_stallreq", {31'b0, stallreq_o}, 32'd0);
    check("annul_wreg",     {31'b0, wreg_o},     32'd0);
    check("annul_valid",    {31'b0, md_valid_o}, 32'd0);
    @(posedge clk);
    #1;
    annul_i = 1'b0;
    drive_nop();
    do_op("div_after_annul", 3'd4, 32'd9, 32'd3, 0);

    for (int i = 0; i < 24; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2:       b = 32'($urandom_range(1, 255));
        3:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
        default: b = $urandom;
      endcase
      do_op($sformatf("rand%0d_f3_%0d", i, f3), f3, a, b, (i % 5 == 4) ? 2 : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
